// File: rtl/interfaz_botones_pkg.sv
// interfaz_botones_pkg: shared debounce state encoding and default sizing constants.
package interfaz_botones_pkg;
  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    CONF_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    CONF_LOW  = 2'd3
  } db_state_t;
  localparam int DEF_N_BTN     = 5;
  localparam int DEF_DB_CYCLES = 50000;
  localparam int DEF_CNT_W     = 16;
endpackage

// File: rtl/interfaz_botones_debounce.sv
// boton_debounce: 2-flop synchronizer plus confirm-count debouncer for one button.
module boton_debounce
  import interfaz_botones_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES);
  logic [1:0] sync;
  logic s;
  db_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic press_nxt, release_nxt;
  assign s = sync[1];
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= '0;
    else sync <= {sync[0], btn_in};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= ST_LOW;
      cnt         <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  // Counter saturates at DB_MAX: the accepting sample clears it, so it never wraps.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      ST_LOW:
        if (s) begin
          state_nxt = CONF_HIGH;
          cnt_nxt   = CNT_W'(1);
        end
      CONF_HIGH:
        if (!s) state_nxt = ST_LOW;
        else if (cnt < DB_MAX) cnt_nxt = cnt + 1'b1;
        else begin
          state_nxt = ST_HIGH;
          press_nxt = 1'b1;
        end
      ST_HIGH:
        if (!s) begin
          state_nxt = CONF_LOW;
          cnt_nxt   = CNT_W'(1);
        end
      CONF_LOW:
        if (s) state_nxt = ST_HIGH;
        else if (cnt < DB_MAX) cnt_nxt = cnt + 1'b1;
        else begin
          state_nxt   = ST_LOW;
          release_nxt = 1'b1;
        end
    endcase
  end
  // Accepted level is high in ST_HIGH and while confirming a release.
  always_comb btn_level = (state == ST_HIGH) || (state == CONF_LOW);
endmodule

// File: rtl/interfaz_botones.sv
// interfaz_botones: N_BTN independent button debouncers with a combined press flag.
module interfaz_botones
  import interfaz_botones_pkg::*;
#(
  parameter int N_BTN     = DEF_N_BTN,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    boton_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_db (
      .clk        (clk),
      .reset      (reset),
      .btn_in     (btn_in[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end
  // OR of flop outputs, so it lines up with btn_press in the same cycle.
  assign any_press = |btn_press;
endmodule
